// File: rtl/hamming_decode_pipe.sv
// Two-stage pipelined Hamming SEC decoder with valid/ready streaming and
// saturating corrected/uncorrectable word counters for SEU monitoring.

package hamming_decode_pipe_pkg;

    // Smallest parity count p such that 2**p covers data, parity and the zero syndrome.
    function automatic int calc_par_width(input int data_width);
        int p;
        p = 1;
        while ((32'sd1 <<< p) < (data_width + p + 1)) begin
            p = p + 1;
        end
        return p;
    endfunction

endpackage

module hamming_decode_pipe
    import hamming_decode_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16,
    localparam int PAR_WIDTH = calc_par_width(DATA_WIDTH),
    localparam int CW_WIDTH  = DATA_WIDTH + PAR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CW_WIDTH-1:0]   cw_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [PAR_WIDTH-1:0]  out_syndrome,
    output logic                  out_corr,
    output logic                  out_uncorr,
    input  logic                  cnt_clear,
    output logic [CNT_WIDTH-1:0]  corr_cnt,
    output logic [CNT_WIDTH-1:0]  uncorr_cnt
);

    localparam int IDX_W = $clog2(CW_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [PAR_WIDTH-1:0] CW_POS_MAX = PAR_WIDTH'(CW_WIDTH);
    localparam logic [CW_WIDTH-1:0]  CW_ONE = {{(CW_WIDTH-1){1'b0}}, 1'b1};

    // The syndrome equals the XOR of the positions of every set bit.
    function automatic logic [PAR_WIDTH-1:0] syndrome_f(input logic [CW_WIDTH-1:0] cw);
        logic [PAR_WIDTH-1:0] syn;
        logic [IDX_W-1:0]     bi;
        syn = {PAR_WIDTH{1'b0}};
        for (int pos = 1; pos <= CW_WIDTH; pos++) begin
            bi = IDX_W'(pos - 1);
            if (cw[bi]) begin
                syn = syn ^ PAR_WIDTH'(pos);
            end else begin
                syn = syn;
            end
        end
        return syn;
    endfunction

    // Non-power-of-two positions carry data, shifted in so the lowest position lands at bit 0.
    function automatic logic [DATA_WIDTH-1:0] extract_f(input logic [CW_WIDTH-1:0] cw);
        logic [DATA_WIDTH-1:0] data;
        logic [IDX_W-1:0]      bi;
        data = {DATA_WIDTH{1'b0}};
        for (int pos = 1; pos <= CW_WIDTH; pos++) begin
            bi = IDX_W'(pos - 1);
            if ((pos & (pos - 1)) != 0) begin
                data = {cw[bi], data[DATA_WIDTH-1:1]};
            end else begin
                data = data;
            end
        end
        return data;
    endfunction

    logic                  s1_valid_q, s1_valid_d;
    logic [CW_WIDTH-1:0]   s1_cw_q, s1_cw_d;
    logic [PAR_WIDTH-1:0]  s1_syn_q, s1_syn_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [PAR_WIDTH-1:0]  out_syn_q, out_syn_d;
    logic                  out_corr_q, out_corr_d;
    logic                  out_uncorr_q, out_uncorr_d;
    logic [CNT_WIDTH-1:0]  corr_cnt_q, corr_cnt_d;
    logic [CNT_WIDTH-1:0]  uncorr_cnt_q, uncorr_cnt_d;

    logic                  s2_adv_s;
    logic                  s1_adv_s;
    logic                  out_hs_s;
    logic                  in_range_s;
    logic [CW_WIDTH-1:0]   fixed_cw_s;

    assign s2_adv_s = !out_valid_q || out_ready;
    assign s1_adv_s = !s1_valid_q || s2_adv_s;
    assign out_hs_s = out_valid_q && out_ready;
    assign in_ready = s1_adv_s;

    // Correction of the word held in stage 1.
    always_comb begin
        in_range_s = (s1_syn_q != {PAR_WIDTH{1'b0}}) && (s1_syn_q <= CW_POS_MAX);
        fixed_cw_s = s1_cw_q;
        if (in_range_s) begin
            fixed_cw_s = s1_cw_q ^ (CW_ONE << (s1_syn_q - PAR_WIDTH'(1)));
        end else begin
            fixed_cw_s = s1_cw_q;
        end
    end

    // Pipeline and counter next-state.
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_cw_d      = s1_cw_q;
        s1_syn_d     = s1_syn_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_syn_d    = out_syn_q;
        out_corr_d   = out_corr_q;
        out_uncorr_d = out_uncorr_q;
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;

        if (s1_adv_s) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_cw_d  = cw_in;
                s1_syn_d = syndrome_f(cw_in);
            end else begin
                s1_cw_d  = s1_cw_q;
                s1_syn_d = s1_syn_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end

        // Payload fields only change when a real word moves into stage 2.
        if (s2_adv_s) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d   = extract_f(fixed_cw_s);
                out_syn_d    = s1_syn_q;
                out_corr_d   = in_range_s;
                out_uncorr_d = (s1_syn_q > CW_POS_MAX);
            end else begin
                out_data_d   = out_data_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end

        if (cnt_clear) begin
            corr_cnt_d   = {CNT_WIDTH{1'b0}};
            uncorr_cnt_d = {CNT_WIDTH{1'b0}};
        end else begin
            if (out_hs_s && out_corr_q && (corr_cnt_q != CNT_MAX)) begin
                corr_cnt_d = corr_cnt_q + CNT_WIDTH'(1);
            end else begin
                corr_cnt_d = corr_cnt_q;
            end
            if (out_hs_s && out_uncorr_q && (uncorr_cnt_q != CNT_MAX)) begin
                uncorr_cnt_d = uncorr_cnt_q + CNT_WIDTH'(1);
            end else begin
                uncorr_cnt_d = uncorr_cnt_q;
            end
        end
    end

    // State registers; reset discards any in-flight words.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q   <= 1'b0;
            s1_cw_q      <= {CW_WIDTH{1'b0}};
            s1_syn_q     <= {PAR_WIDTH{1'b0}};
            out_valid_q  <= 1'b0;
            out_data_q   <= {DATA_WIDTH{1'b0}};
            out_syn_q    <= {PAR_WIDTH{1'b0}};
            out_corr_q   <= 1'b0;
            out_uncorr_q <= 1'b0;
            corr_cnt_q   <= {CNT_WIDTH{1'b0}};
            uncorr_cnt_q <= {CNT_WIDTH{1'b0}};
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_cw_q      <= s1_cw_d;
            s1_syn_q     <= s1_syn_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_syn_q    <= out_syn_d;
            out_corr_q   <= out_corr_d;
            out_uncorr_q <= out_uncorr_d;
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_syndrome = out_syn_q;
    assign out_corr     = out_corr_q;
    assign out_uncorr   = out_uncorr_q;
    assign corr_cnt     = corr_cnt_q;
    assign uncorr_cnt   = uncorr_cnt_q;

endmodule
